// File: rtl/physics_pkg.sv
// Shared types for the collision resolver: FSM states and divider timing.
package physics_pkg;

    typedef enum logic [2:0] {IDLE, SCAN, LOAD, DIV, WRITE, FINISH} state_t;

    // One quotient bit per cycle over a (2*width+3)-bit numerator.
    function automatic int DIV_LATENCY(input int width);
        return 2 * width + 3;
    endfunction

endpackage

// File: rtl/serial_divider.sv
// Sign-magnitude restoring divider: signed numerator, unsigned non-zero divisor,
// quotient truncated toward zero, done pulses NW cycles after start.
module serial_divider #(
    parameter int NW = 67,
    parameter int DW = 33
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic [NW-1:0] num_i,
    input  logic [DW-1:0] den_i,
    output logic [NW-1:0] quo_o,
    output logic          done_o
);
    localparam int CW = $clog2(NW + 1);

    logic [NW-1:0] mag_q;
    logic [DW-1:0] rem_q, den_q;
    logic [CW-1:0] cnt_q;
    logic          neg_q, done_q;
    logic [DW:0]   rem_sh, diff;
    logic          ge;

    always_comb begin
        rem_sh = {rem_q, mag_q[NW-1]};
        diff   = rem_sh - {1'b0, den_q};
        ge     = (rem_sh >= {1'b0, den_q});
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mag_q  <= '0;
            rem_q  <= '0;
            den_q  <= '0;
            cnt_q  <= '0;
            neg_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                mag_q <= num_i[NW-1] ? (~num_i + 1'b1) : num_i;
                neg_q <= num_i[NW-1];
                rem_q <= '0;
                den_q <= den_i;
                cnt_q <= CW'(NW);
            end else if (cnt_q != '0) begin
                // Dividend bits shift out of mag_q as quotient bits shift in.
                mag_q  <= {mag_q[NW-2:0], ge};
                rem_q  <= DW'(ge ? diff : rem_sh);
                cnt_q  <= cnt_q - 1'b1;
                done_q <= (cnt_q == CW'(1));
            end
        end
    end

    assign quo_o  = neg_q ? (~mag_q + 1'b1) : mag_q;
    assign done_o = done_q;

endmodule

// File: rtl/collision_resolver.sv
// Resolves elastic collisions pair by pair over the upper triangle of the
// collision matrix, sharing one serial divider for all four quotients per pair.
module collision_resolver
    import physics_pkg::*;
#(
    parameter int SPRITES    = 9,
    parameter int DIMENSIONS = 2,
    parameter int WIDTH      = 32
) (
    input  logic                                          clock,
    input  logic                                          reset_L,
    input  logic                                          start,
    input  logic [SPRITES-1:0][SPRITES-1:0]               collision,
    input  logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0] velocities,
    input  logic [SPRITES-1:0][WIDTH-1:0]                 masses,
    output logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0] new_velocities,
    output logic                                          busy,
    output logic                                          done,
    output logic [7:0]                                    pair_count
);
    localparam int NW = DIV_LATENCY(WIDTH);
    localparam int DW = WIDTH + 1;
    localparam int IW = (SPRITES > 2) ? $clog2(SPRITES) : 1;
    localparam logic [IW-1:0] LAST = IW'(SPRITES - 1);
    localparam logic signed [NW-1:0] QMAX = $signed({{(NW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}});
    localparam logic signed [NW-1:0] QMIN = $signed({{(NW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}});

    state_t state_q, state_d;

    logic [SPRITES-1:0][SPRITES-1:0]               coll_q;
    logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0] vel_q, newv_q;
    logic [SPRITES-1:0][WIDTH-1:0]                 mass_q;
    logic [3:0][WIDTH-1:0]                         res_q;
    logic [IW-1:0] i_q, j_q, nxt_i, nxt_j, a_idx, b_idx;
    logic [1:0]    op_q;
    logic [7:0]    cnt_q, pc_q;
    logic          fin_q, done_q;

    logic                 ax, pair_hit, last_pair, div_done;
    logic signed [NW-1:0] ma_s, mb_s, va_s, vb_s, num, quo_s;
    logic [DW-1:0]        den;
    logic [NW-1:0]        quo;
    logic [WIDTH-1:0]     sat;

    // Operand order: (i,x), (i,y), (j,x), (j,y); a is the sprite being solved.
    always_comb begin
        a_idx     = op_q[1] ? j_q : i_q;
        b_idx     = op_q[1] ? i_q : j_q;
        ax        = op_q[0];
        ma_s      = $signed(NW'(mass_q[a_idx]));
        mb_s      = $signed(NW'(mass_q[b_idx]));
        va_s      = NW'($signed(vel_q[a_idx][ax]));
        vb_s      = NW'($signed(vel_q[b_idx][ax]));
        num       = (ma_s - mb_s) * va_s + (mb_s + mb_s) * vb_s;
        den       = {1'b0, mass_q[i_q]} + {1'b0, mass_q[j_q]};
        pair_hit  = coll_q[i_q][j_q] && (den != '0);
        last_pair = (i_q == LAST - 1'b1) && (j_q == LAST);
        nxt_i     = (j_q == LAST) ? i_q + 1'b1 : i_q;
        nxt_j     = (j_q == LAST) ? i_q + IW'(2) : j_q + 1'b1;
        quo_s     = $signed(quo);
        sat       = (quo_s > QMAX) ? QMAX[WIDTH-1:0] :
                    (quo_s < QMIN) ? QMIN[WIDTH-1:0] : quo_s[WIDTH-1:0];
    end

    serial_divider #(.NW(NW), .DW(DW)) u_div (
        .clk_i   (clock),
        .rst_ni  (reset_L),
        .start_i (state_q == LOAD),
        .num_i   (num),
        .den_i   (den),
        .quo_o   (quo),
        .done_o  (div_done)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (start) state_d = SCAN;
            SCAN: begin
                if (fin_q)          state_d = FINISH;
                else if (pair_hit)  state_d = LOAD;
                else if (last_pair) state_d = FINISH;
            end
            LOAD:   state_d = DIV;
            DIV:    if (div_done) state_d = (op_q == 2'd3) ? WRITE : LOAD;
            WRITE:  state_d = SCAN;
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            coll_q <= '0;
            vel_q  <= '0;
            mass_q <= '0;
            res_q  <= '0;
            newv_q <= '0;
            i_q    <= '0;
            j_q    <= '0;
            op_q   <= '0;
            cnt_q  <= '0;
            pc_q   <= '0;
            fin_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    coll_q <= collision;
                    vel_q  <= velocities;
                    mass_q <= masses;
                    i_q    <= '0;
                    j_q    <= IW'(1);
                    op_q   <= '0;
                    cnt_q  <= '0;
                    fin_q  <= 1'b0;
                end
                SCAN: begin
                    if (!fin_q && pair_hit) op_q <= '0;
                    else if (!fin_q && !last_pair) begin
                        i_q <= nxt_i;
                        j_q <= nxt_j;
                    end
                end
                DIV: if (div_done) begin
                    res_q[op_q] <= sat;
                    op_q        <= op_q + 1'b1;
                end
                WRITE: begin
                    vel_q[i_q][0] <= res_q[0];
                    vel_q[i_q][1] <= res_q[1];
                    vel_q[j_q][0] <= res_q[2];
                    vel_q[j_q][1] <= res_q[3];
                    cnt_q         <= cnt_q + 1'b1;
                    if (last_pair) fin_q <= 1'b1;
                    else begin
                        i_q <= nxt_i;
                        j_q <= nxt_j;
                    end
                end
                FINISH: begin
                    newv_q <= vel_q;
                    pc_q   <= cnt_q;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign new_velocities = newv_q;
    assign pair_count     = pc_q;
    assign busy           = (state_q != IDLE);
    assign done           = done_q;

endmodule
